// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store front end for a word-wide BRAM without byte enables (optional MEM_MISALIGN_CHK_EN)
module mem_access_ctrl #(
  parameter int WORDS      = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [1:0]            size_i,
  input  logic                  unsigned_i,
  input  logic [31:0]           addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o,
  output logic [WORDS-1:0]      mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  mem_wr_n_o,
  output logic                  mem_rd_n_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i
);

  typedef enum logic [2:0] {IDLE, READ, RMW_RD, RMW_WR, WRITE} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic [1:0]              lane_q, lane_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [WORDS-1:0]        mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_data_q, mem_data_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    misalign;
  logic [7:0]              byte_sel;
  logic [15:0]             half_sel;
  logic [DATA_WIDTH-1:0]   load_ext;
  logic [DATA_WIDTH-1:0]   merged;
  logic                    unused_addr;

  // High address bits wrap: only [WORDS+1:0] select a byte in the memory.
  assign unused_addr = ^addr_i[31:WORDS+2];

`ifdef MEM_MISALIGN_CHK_EN
  // Half on odd byte, or word (size 1x) not on a 4-byte boundary.
  assign misalign = (size_i == 2'b01 && addr_i[0]) || (size_i[1] && addr_i[1:0] != 2'b00);
`else
  // Without the check, half/word accesses are force-aligned by ignoring low lane bits.
  assign misalign = 1'b0;
`endif

  // Strobes and ready decode directly from the registered state so they are glitch-free at the memory's negedge.
  assign ready_o    = (state_q == IDLE);
  assign mem_rd_n_o = !(state_q == READ || state_q == RMW_RD);
  assign mem_wr_n_o = !(state_q == RMW_WR || state_q == WRITE);
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;
  assign rdata_o    = rdata_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

  // Lane extraction and sign/zero extension of the returned memory word.
  always_comb begin
    byte_sel = mem_data_i[7:0];
    case (lane_q)
      2'd1:    byte_sel = mem_data_i[15:8];
      2'd2:    byte_sel = mem_data_i[23:16];
      2'd3:    byte_sel = mem_data_i[31:24];
      default: byte_sel = mem_data_i[7:0];
    endcase
    half_sel = lane_q[1] ? mem_data_i[31:16] : mem_data_i[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{!uns_q && byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{!uns_q && half_sel[15]}}, half_sel};
      default: load_ext = mem_data_i;
    endcase
  end

  // Read-modify-write merge: old word with the target byte or half replaced by store data.
  always_comb begin
    merged = mem_data_i;
    if (size_q == 2'b00) begin
      case (lane_q)
        2'd1:    merged = {mem_data_i[31:16], wdata_q[7:0], mem_data_i[7:0]};
        2'd2:    merged = {mem_data_i[31:24], wdata_q[7:0], mem_data_i[15:0]};
        2'd3:    merged = {wdata_q[7:0], mem_data_i[23:0]};
        default: merged = {mem_data_i[31:8], wdata_q[7:0]};
      endcase
    end else begin
      merged = lane_q[1] ? {wdata_q[15:0], mem_data_i[15:0]} : {mem_data_i[31:16], wdata_q[15:0]};
    end
  end

  // Next-state and datapath updates; done/err are single-cycle pulses by default.
  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    uns_d      = uns_q;
    lane_d     = lane_q;
    wdata_d    = wdata_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          if (misalign) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            size_d     = size_i;
            uns_d      = unsigned_i;
            lane_d     = addr_i[1:0];
            wdata_d    = wdata_i;
            mem_addr_d = addr_i[WORDS+1:2];
            if (!we_i) begin
              state_d = READ;
            end else if (size_i[1]) begin
              state_d    = WRITE;
              mem_data_d = wdata_i;
            end else begin
              state_d = RMW_RD;
            end
          end
        end
      end
      READ: begin
        state_d = IDLE;
        rdata_d = load_ext;
        done_d  = 1'b1;
      end
      RMW_RD: begin
        state_d    = RMW_WR;
        mem_data_d = merged;
      end
      RMW_WR, WRITE: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset; reset aborts any in-flight write.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      lane_q     <= 2'b00;
      wdata_q    <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      rdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      lane_q     <= lane_d;
      wdata_q    <= wdata_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed bench for mem_access_ctrl (default build or MEM_MISALIGN_CHK_EN)
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        req_i;
  logic        we_i;
  logic [1:0]  size_i;
  logic        unsigned_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        ready_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic [9:0]  mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_wr_n_o;
  logic        mem_rd_n_o;
  logic [31:0] mem_rdata = 32'h0;

  logic [31:0] mem [0:1023];
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          both_cnt = 0;
  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = 10'd0;
  logic [31:0] pre_data = 32'h0;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .req_i      (req_i),
    .we_i       (we_i),
    .size_i     (size_i),
    .unsigned_i (unsigned_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .ready_o    (ready_o),
    .done_o     (done_o),
    .rdata_o    (rdata_o),
    .err_o      (err_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_wr_n_o (mem_wr_n_o),
    .mem_rd_n_o (mem_rd_n_o),
    .mem_data_i (mem_rdata)
  );

  // BRAM: samples strobes on negedge, read data valid at the following posedge.
  always @(negedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (!mem_rd_n_o) begin
      mem_rdata <= mem[mem_addr_o];
      rd_cnt    <= rd_cnt + 1;
    end
    if (!mem_wr_n_o) begin
      mem[mem_addr_o] <= mem_data_o;
      wr_cnt          <= wr_cnt + 1;
    end
    if (!mem_rd_n_o && !mem_wr_n_o) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [9:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(negedge clk);
    #1 pre_we = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic op(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                    input logic [31:0] a, input logic [31:0] wd, input int lat,
                    input int nrd, input int nwr, input logic xerr, input logic [31:0] xrd);
    int cyc;
    int rd0;
    int wr0;
    rd0        = rd_cnt;
    wr0        = wr_cnt;
    req_i      = 1'b1;
    we_i       = we;
    size_i     = sz;
    unsigned_i = uns;
    addr_i     = a;
    wdata_i    = wd;
    @(posedge clk);
    #1 req_i = 1'b0;
    cyc = 1;
    if (lat > 1) begin
      chk({tag, " ready_busy"}, {31'd0, ready_o}, 32'd0);
      chk({tag, " mem_addr"}, {22'd0, mem_addr_o}, {22'd0, a[11:2]});
    end
    while (done_o !== 1'b1 && cyc < 8) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk({tag, " latency"}, cyc, lat);
    chk({tag, " done"}, {31'd0, done_o}, 32'd1);
    chk({tag, " err"}, {31'd0, err_o}, {31'd0, xerr});
    chk({tag, " rdata"}, rdata_o, xrd);
    chk({tag, " rd_cycles"}, rd_cnt - rd0, nrd);
    chk({tag, " wr_cycles"}, wr_cnt - wr0, nwr);
  endtask

  initial begin
    int wr0;
    int rd0;
    logic saw_done;
    reset_i = 1'b1; req_i = 1'b0; we_i = 1'b0; size_i = 2'b00;
    unsigned_i = 1'b0; addr_i = 32'h0; wdata_i = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;
    chk("rst ready", {31'd0, ready_o}, 32'd1);
    chk("rst done", {31'd0, done_o}, 32'd0);
    chk("rst err", {31'd0, err_o}, 32'd0);
    chk("rst rdata", rdata_o, 32'h0);
    chk("rst wr_n", {31'd0, mem_wr_n_o}, 32'd1);
    chk("rst rd_n", {31'd0, mem_rd_n_o}, 32'd1);
    chk("rst mem_addr", {22'd0, mem_addr_o}, 32'd0);
    chk("rst mem_data", mem_data_o, 32'h0);

    poke(10'd10, 32'h55AA3312);
    op("LW 28",   0, 2'b10, 0, 32'h0000_0028, 32'h0, 2, 1, 0, 0, 32'h55AA3312);
    op("LW wrap", 0, 2'b10, 0, 32'h0000_1028, 32'h0, 2, 1, 0, 0, 32'h55AA3312);
    op("LB 2B",   0, 2'b00, 0, 32'h0000_002B, 32'h0, 2, 1, 0, 0, 32'h00000055);
    op("LB 2A",   0, 2'b00, 0, 32'h0000_002A, 32'h0, 2, 1, 0, 0, 32'hFFFFFFAA);
    op("LBU 2A",  0, 2'b00, 1, 32'h0000_002A, 32'h0, 2, 1, 0, 0, 32'h000000AA);
    op("LH 2A",   0, 2'b01, 0, 32'h0000_002A, 32'h0, 2, 1, 0, 0, 32'h000055AA);
    op("LH 28",   0, 2'b01, 0, 32'h0000_0028, 32'h0, 2, 1, 0, 0, 32'h00003312);
    op("LB 28",   0, 2'b00, 0, 32'h0000_0028, 32'h0, 2, 1, 0, 0, 32'h00000012);
    poke(10'd10, 32'hBBAA1136);
    op("LHU 2A",  0, 2'b01, 1, 32'h0000_002A, 32'h0, 2, 1, 0, 0, 32'h0000BBAA);
    op("LH 2A s", 0, 2'b01, 0, 32'h0000_002A, 32'h0, 2, 1, 0, 0, 32'hFFFFBBAA);

    poke(10'd10, 32'h55AA3312);
    op("SB 29", 1, 2'b00, 0, 32'h0000_0029, 32'h123456E1, 3, 1, 1, 0, 32'hFFFFBBAA);
    chk("SB 29 mem", mem[10], 32'h55AAE112);
    poke(10'd10, 32'h55AA3312);
    op("SH 2A", 1, 2'b01, 0, 32'h0000_002A, 32'h00001234, 3, 1, 1, 0, 32'hFFFFBBAA);
    chk("SH 2A mem", mem[10], 32'h12343312);

    op("SW 28", 1, 2'b10, 0, 32'h0000_0028, 32'hDEADBEEF, 2, 0, 1, 0, 32'hFFFFBBAA);
    op("LW b2b", 0, 2'b10, 0, 32'h0000_0028, 32'h0, 2, 1, 0, 0, 32'hDEADBEEF);
    chk("SW 28 mem", mem[10], 32'hDEADBEEF);

    poke(10'd10, 32'h55AA3312);
`ifdef MEM_MISALIGN_CHK_EN
    op("LW 2A mis", 0, 2'b10, 0, 32'h0000_002A, 32'h0, 1, 0, 0, 1, 32'hDEADBEEF);
    op("LH 2B mis", 0, 2'b01, 0, 32'h0000_002B, 32'h0, 1, 0, 0, 1, 32'hDEADBEEF);
    op("SW 29 mis", 1, 2'b10, 0, 32'h0000_0029, 32'h01020304, 1, 0, 0, 1, 32'hDEADBEEF);
`else
    op("LW 2A aln", 0, 2'b10, 0, 32'h0000_002A, 32'h0, 2, 1, 0, 0, 32'h55AA3312);
    op("LH 2B aln", 0, 2'b01, 0, 32'h0000_002B, 32'h0, 2, 1, 0, 0, 32'h000055AA);
    op("LH 29 aln", 0, 2'b01, 1, 32'h0000_0029, 32'h0, 2, 1, 0, 0, 32'h00003312);
`endif
    chk("mis mem", mem[10], 32'h55AA3312);

    wr0 = wr_cnt;
    rd0 = rd_cnt;
    req_i = 1'b1; we_i = 1'b1; size_i = 2'b00; unsigned_i = 1'b0;
    addr_i = 32'h0000_0028; wdata_i = 32'h000000FF;
    @(posedge clk);
    #1 req_i = 1'b0;
    reset_i = 1'b1;
    chk("rstmid ready_busy", {31'd0, ready_o}, 32'd0);
    @(posedge clk);
    #1 reset_i = 1'b0;
    chk("rstmid wr_n", {31'd0, mem_wr_n_o}, 32'd1);
    chk("rstmid ready", {31'd0, ready_o}, 32'd1);
    chk("rstmid done", {31'd0, done_o}, 32'd0);
    chk("rstmid rdata", rdata_o, 32'h0);
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1 saw_done = saw_done | done_o;
    end
    chk("rstmid no_done", {31'd0, saw_done}, 32'd0);
    chk("rstmid rd_cycles", rd_cnt - rd0, 1);
    chk("rstmid wr_cycles", wr_cnt - wr0, 0);
    chk("rstmid mem", mem[10], 32'h55AA3312);
    chk("strobe overlap", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
